// File: rtl/timer_pkg.sv
// Shared types and constants for the timer60 control sequencer.
// Also reused by the clock-set UI.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } tctrl_state_t;

    // At most one button event is acted on per cycle.
    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_STOP  = 3'd1,
        EV_LOAD  = 3'd2,
        EV_PAUSE = 3'd3,
        EV_START = 3'd4
    } tctrl_event_t;

    localparam logic [7:0] TC_UP_BCD   = 8'h59;
    localparam logic [7:0] TC_DOWN_BCD = 8'h00;
    localparam int         DIV_DEFAULT = 50_000_000;

    // Priority is stop > load > pause > start. Lower-priority presses are dropped.
    function automatic tctrl_event_t pick_event(input logic stop, input logic load,
                                                input logic pause, input logic start);
        tctrl_event_t ev;
        if (stop)       ev = EV_STOP;
        else if (load)  ev = EV_LOAD;
        else if (pause) ev = EV_PAUSE;
        else if (start) ev = EV_START;
        else            ev = EV_NONE;
        return ev;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a push-button level.
// Emits one press per button push; a held button does not repeat.
module btn_edge (
    input  logic Clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic btn_q;
    logic btn_prev;

    always_ff @(posedge Clk) begin
        if (reset) begin
            btn_q    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_q    <= btn;
            btn_prev <= btn_q;
        end
    end

    assign press = btn_q & ~btn_prev;

endmodule

// File: rtl/timer60_ctrl.sv
// Control sequencer for the 0-59 timer: button events, count-tick prescaler
// and terminal-count alarm. All outputs are registered.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting; direction follows mode_down
// ST_LOAD   | one-cycle set_time pulse to timer60, then back to idle
// ST_RUN    | prescaler counting, tick every DIV cycles
// ST_PAUSED | prescaler held with its phase, no ticks
// ST_DONE   | terminal count reached, alarm raised until stop/start
module timer60_ctrl
    import timer_pkg::*;
#(
    parameter int         DIV     = DIV_DEFAULT,
    parameter logic [7:0] TC_UP   = TC_UP_BCD,
    parameter logic [7:0] TC_DOWN = TC_DOWN_BCD
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       btn_load,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic       mode_down,
    input  logic [7:0] count_in,
    output logic       tm_set_time,
    output logic       tm_start,
    output logic       tm_pause,
    output logic       tm_stop,
    output logic       tm_reset,
    output logic       tm_updown,
    output logic       tick,
    output logic       alarm,
    output logic [2:0] state_o
);

    localparam int             PW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);

    tctrl_state_t  state;
    tctrl_event_t  ev;
    logic [PW-1:0] presc;
    logic          press_load;
    logic          press_start;
    logic          press_pause;
    logic          press_stop;
    logic [7:0]    tc_value;

    btn_edge u_edge_load  (.Clk(Clk), .reset(reset), .btn(btn_load),  .press(press_load));
    btn_edge u_edge_start (.Clk(Clk), .reset(reset), .btn(btn_start), .press(press_start));
    btn_edge u_edge_pause (.Clk(Clk), .reset(reset), .btn(btn_pause), .press(press_pause));
    btn_edge u_edge_stop  (.Clk(Clk), .reset(reset), .btn(btn_stop),  .press(press_stop));

    always_comb begin
        ev = pick_event(press_stop, press_load, press_pause, press_start);
    end

    assign tc_value = tm_updown ? TC_UP : TC_DOWN;
    assign state_o  = state;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= '0;
            tm_set_time <= 1'b0;
            tm_start    <= 1'b0;
            tm_pause    <= 1'b0;
            tm_stop     <= 1'b0;
            tm_reset    <= 1'b1;
            tm_updown   <= 1'b1;
            tick        <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            tm_set_time <= 1'b0;
            tm_stop     <= 1'b0;
            tm_reset    <= 1'b0;
            tick        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tm_updown <= ~mode_down;
                    if (ev == EV_LOAD) begin
                        state       <= ST_LOAD;
                        tm_set_time <= 1'b1;
                    end else if (ev == EV_START) begin
                        state    <= ST_RUN;
                        tm_start <= 1'b1;
                        presc    <= '0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (ev == EV_STOP) begin
                        state    <= ST_IDLE;
                        tm_start <= 1'b0;
                        tm_stop  <= 1'b1;
                    end else if (ev == EV_PAUSE) begin
                        state    <= ST_PAUSED;
                        tm_start <= 1'b0;
                        tm_pause <= 1'b1;
                    end else if (tick && (count_in == tc_value)) begin
                        state    <= ST_DONE;
                        tm_start <= 1'b0;
                        alarm    <= 1'b1;
                    end else begin
                        // Prescaler only advances on cycles that stay in RUN, so a
                        // pause never swallows a tick or loses phase.
                        tick  <= (presc == P_LAST);
                        presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (ev == EV_STOP) begin
                        state    <= ST_IDLE;
                        tm_pause <= 1'b0;
                        tm_stop  <= 1'b1;
                    end else if (ev == EV_START) begin
                        state    <= ST_RUN;
                        tm_pause <= 1'b0;
                        tm_start <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ev == EV_STOP) begin
                        state   <= ST_IDLE;
                        alarm   <= 1'b0;
                        tm_stop <= 1'b1;
                    end else if (ev == EV_START) begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tm_start <= 1'b0;
                    tm_pause <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer60_ctrl.sv
// Bench for timer60_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_timer60_ctrl;

    localparam int DIV = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_load = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_stop = 1'b0;
    logic       mode_down = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       tm_set_time, tm_start, tm_pause, tm_stop, tm_reset, tm_updown, tick, alarm;
    logic [2:0] state_o;

    timer60_ctrl #(.DIV(DIV)) dut (
        .Clk(Clk), .reset(reset),
        .btn_load(btn_load), .btn_start(btn_start), .btn_pause(btn_pause), .btn_stop(btn_stop),
        .mode_down(mode_down), .count_in(count_in),
        .tm_set_time(tm_set_time), .tm_start(tm_start), .tm_pause(tm_pause), .tm_stop(tm_stop),
        .tm_reset(tm_reset), .tm_updown(tm_updown), .tick(tick), .alarm(alarm),
        .state_o(state_o)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model. States: 0 idle, 1 load, 2 run, 3 paused, 4 done.
    int       m_state = 0;
    int       m_ph = 0;
    bit [3:0] m_q = 0;      // sampled buttons {stop, load, pause, start}
    bit [3:0] m_prev = 0;
    bit       m_stop = 0, m_tick = 0, m_treset = 1, m_ud = 1;

    task automatic model_edge();
        bit [3:0] pr;
        int       ev;
        bit       old_tick;
        bit [7:0] tc;
        if (reset) begin
            m_state = 0; m_ph = 0; m_q = 0; m_prev = 0;
            m_stop = 0; m_tick = 0; m_treset = 1; m_ud = 1;
            return;
        end
        pr       = m_q & ~m_prev;
        old_tick = m_tick;
        m_stop   = 0; m_tick = 0; m_treset = 0;
        ev = pr[3] ? 1 : pr[2] ? 2 : pr[1] ? 3 : pr[0] ? 4 : 0;
        tc = m_ud ? 8'h59 : 8'h00;
        case (m_state)
            0: begin
                m_ud = !mode_down;
                if (ev == 2) m_state = 1;
                else if (ev == 4) begin m_state = 2; m_ph = 0; end
            end
            1: m_state = 0;
            2: begin
                if (ev == 1) begin m_state = 0; m_stop = 1; end
                else if (ev == 3) m_state = 3;
                else if (old_tick && count_in == tc) m_state = 4;
                else begin
                    m_ph = m_ph + 1;
                    if (m_ph == DIV) begin m_ph = 0; m_tick = 1; end
                end
            end
            3: begin
                if (ev == 1) begin m_state = 0; m_stop = 1; end
                else if (ev == 4) m_state = 2;
            end
            4: begin
                if (ev == 1) begin m_state = 0; m_stop = 1; end
                else if (ev == 4) m_state = 0;
            end
            default: m_state = 0;
        endcase
        m_prev = m_q;
        m_q    = {btn_stop, btn_load, btn_pause, btn_start};
    endtask

    function automatic logic [10:0] model_vec();
        logic [2:0] s;
        s = 3'(m_state);
        return {s, m_state == 1, m_state == 2, m_state == 3, m_stop, m_treset, m_ud, m_tick, m_state == 4};
    endfunction

    wire [10:0] dut_vec = {state_o, tm_set_time, tm_start, tm_pause, tm_stop,
                           tm_reset, tm_updown, tick, alarm};

    // One clock: model follows the edge, outputs are compared mid-cycle.
    task automatic cyc();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("outs", 32'(dut_vec), 32'(model_vec()));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hi, t1, t2, seen, stops, pauses;
        @(negedge Clk);
        idle_n(2);
        check("rst_vals", 32'(dut_vec), 32'(11'b000_0_0_0_0_1_1_0_0));
        reset = 1'b0;
        idle_n(1);
        check("treset_drop", 32'(tm_reset), 32'd0);

        // Load pulse: set_time two edges after the press, exactly one cycle long.
        btn_load = 1'b1; lat = -1; hi = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 1) btn_load = 1'b0;
            if (tm_set_time && lat < 0) lat = i;
            if (tm_set_time) hi++;
        end
        check("load_lat", 32'(lat), 32'd2);
        check("set_pulse_len", 32'(hi), 32'd1);
        check("load_back_idle", 32'(state_o), 32'd0);

        // Up-count run: tick period and first tick, then terminal at 59.
        mode_down = 1'b0; count_in = 8'h12; btn_start = 1'b1; t1 = -1; t2 = -1;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            if (i == 1) btn_start = 1'b0;
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        check("first_tick", 32'(t1), 32'd6);
        check("tick_gap", 32'(t2 - t1), 32'd4);
        count_in = 8'h59; seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc();
            if (alarm && state_o == 3'd4) seen = 1;
        end
        check("done_alarm", 32'(seen), 32'd1);
        idle_n(3);
        check("alarm_held", 32'(alarm), 32'd1);
        btn_stop = 1'b1; cyc(); btn_stop = 1'b0; idle_n(3);
        check("stop_ack", 32'(state_o), 32'd0);

        // Pause keeps prescaler phase.
        count_in = 8'h21;
        btn_start = 1'b1; cyc(); btn_start = 1'b0; idle_n(2);
        btn_pause = 1'b1; cyc(); btn_pause = 1'b0; idle_n(10);
        check("paused", 32'(state_o), 32'd3);
        btn_start = 1'b1; cyc(); btn_start = 1'b0; idle_n(8);

        // Stop and pause on the same cycle: stop wins.
        btn_stop = 1'b1; btn_pause = 1'b1; stops = 0; pauses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            btn_stop = 1'b0; btn_pause = 1'b0;
            stops  += int'(tm_stop);
            pauses += int'(tm_pause);
        end
        check("stop_pulses", 32'(stops), 32'd1);
        check("pause_never", 32'(pauses), 32'd0);

        // Reset mid-run.
        btn_start = 1'b1; cyc(); btn_start = 1'b0; count_in = 8'h30; idle_n(5);
        reset = 1'b1; cyc();
        check("midrun_rst", 32'(dut_vec), 32'(11'b000_0_0_0_0_1_1_0_0));
        reset = 1'b0; cyc();
        check("treset_once", 32'(tm_reset), 32'd0);

        // Direction frozen while running.
        mode_down = 1'b0; idle_n(1);
        btn_start = 1'b1; cyc(); btn_start = 1'b0; idle_n(2);
        mode_down = 1'b1; idle_n(6);
        check("ud_frozen", 32'(tm_updown), 32'd1);
        btn_stop = 1'b1; cyc(); btn_stop = 1'b0; idle_n(3);
        check("ud_follow", 32'(tm_updown), 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(23) == 0) btn_stop  = ~btn_stop;
            if ($urandom_range(15) == 0) btn_load  = ~btn_load;
            if ($urandom_range(11) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(5)  == 0) btn_start = ~btn_start;
            if ($urandom_range(9)  == 0) mode_down = ~mode_down;
            case ($urandom_range(3))
                0:       count_in = 8'h59;
                1:       count_in = 8'h00;
                default: count_in = {4'($urandom_range(5)), 4'($urandom_range(9))};
            endcase
            reset = ($urandom_range(299) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer60_ctrl.md
# timer60_ctrl

Control sequencer for the 0–59 two-digit timer. It turns raw push-button levels into the registered `set_time`/`start`/`stop`/`pause`/`reset` controls and the `UpOrDown` direction that drive the timer60 counter pair. It generates the prescaled count tick that clocks the timer, and detects the terminal count to raise an alarm. It sits between the board I/O and the timer60 instance, and is the only block allowed to drive timer60 control inputs.

## Interface
- `DIV`, 50_000_000: `Clk` cycles per count tick; legal range ≥2.
- `TC_UP`, 8'h59: BCD terminal value in up mode.
- `TC_DOWN`, 8'h00: BCD terminal value in down mode.
- `Clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; clears all state on the next `Clk` edge.
- `btn_load` input 1: level; request load of the initial value.
- `btn_start` input 1: level; start, or resume from pause.
- `btn_pause` input 1: level; pause while running.
- `btn_stop` input 1: level; stop, or acknowledge the alarm.
- `mode_down` input 1: direction request; sampled only in IDLE.
- `count_in` input 8: BCD `{dozen, unit}` fed back from timer60 `Count60`.
- `tm_set_time` output 1: one-cycle pulse to timer60 `set_time`.
- `tm_start` output 1: level; high while RUN.
- `tm_pause` output 1: level; high while PAUSED.
- `tm_stop` output 1: one-cycle pulse to timer60 `stop`.
- `tm_reset` output 1: high for one cycle after `reset` deasserts.
- `tm_updown` output 1: 1 = up; latched direction.
- `tick` output 1: one-cycle count-enable pulse, gated into the timer60 clock path.
- `alarm` output 1: high while DONE.
- `state_o` output 3: current state encoding, for debug and LEDs.

## Operation
- Edge detect: each `btn_*` is registered once. A press is the rising edge of the registered value (reg=1 and prev=0), giving one recognised event per press.
- Event priority when several events share a cycle: stop > load > pause > start. Lower-priority events in that cycle are dropped.
- States: IDLE=0, LOAD=1, RUN=2, PAUSED=3, DONE=4. Encodings 5–7 are illegal and recover to IDLE on the next cycle.
- IDLE:
  - `tm_updown` latches `~mode_down` every cycle.
  - load → LOAD; start → RUN.
- LOAD: `tm_set_time`=1 for exactly this one cycle, then → IDLE unconditionally. All events in LOAD are ignored.
- RUN:
  - The prescaler counts 0..DIV-1, and `tick`=1 on the cycle the prescaler equals DIV-1.
  - pause → PAUSED; stop → IDLE with a `tm_stop` pulse.
  - On a `tick` cycle where `count_in` equals the terminal value for the current direction (TC_UP if up, TC_DOWN if down) → DONE.
- PAUSED: prescaler held (phase retained), `tick`=0. start → RUN; stop → IDLE with `tm_stop`.
- DONE: `alarm`=1, `tick`=0. stop → IDLE with `tm_stop`; start → IDLE without `tm_stop`.
- The prescaler clears to 0 on every entry to RUN from IDLE, and is untouched on PAUSED→RUN.
- `tm_updown` is frozen outside IDLE. Direction cannot change mid-count.

## Timing
- Reset values:
  - state IDLE, prescaler 0, all button registers 0.
  - `tm_set_time`=0, `tm_start`=0, `tm_pause`=0, `tm_stop`=0, `tick`=0, `alarm`=0.
  - `tm_updown`=1, `state_o`=0.
  - `tm_reset`=1 on the first cycle after `reset` falls, 0 thereafter.
- All outputs are registered; no combinational path from inputs to outputs.
- Button-to-output latency: a button rising before edge n is registered at n, recognised at n+1 (state change), and the output updates at n+1.
- First `tick` after RUN entry is DIV cycles after entry.
- A stop arriving on the same cycle as a terminal-count tick wins: → IDLE, no DONE.
- A pause arriving on a `tick` cycle: the tick is still emitted, then the block enters PAUSED.
- `reset` mid-operation aborts any state on the next edge. Pulses in flight are cancelled.
- A held button generates no repeat events.

## Structure
- Package `timer_pkg`: state enum `tctrl_state_t`, the BCD terminal constants, and the default DIV.
- Sub-module `btn_edge` (registered edge detector, one instance per button, reused later by the clock-set UI). The prescaler and FSM stay inline.

## Test plan
- DIV=4, reset then btn_load pulse → `tm_set_time` high exactly one cycle, 2 cycles after the press; state returns to 0.
- DIV=4, mode_down=0, start, drive count_in 8'h59 → `tick` every 4 cycles; DONE (`state_o`=4, `alarm`=1) on the tick where count_in=8'h59.
- DIV=4, start, pause after 2 cycles, hold 10 cycles, start → no tick while paused; first tick 2 cycles after resume (phase kept).
- Stop and pause pressed on the same cycle in RUN → state IDLE, one `tm_stop` pulse, `tm_pause` never high.
- Reset asserted mid-RUN with count_in=8'h30 → next cycle all outputs at reset values; `tm_reset`=1 for one cycle after release.
- Mode_down toggled in RUN → `tm_updown` unchanged until the return to IDLE.
